past_history_reader: RTL and testbench

//  Hardware counterpart of $past(expr, N, gate, @(posedge clk)).
//  - Write side: records the last DEPTH samples of smp_data in a ring buffer.
//  - Read side: answers "value N sampled ticks ago" queries over a valid/ready port.
//  - Used by assertion-monitor logic that needs history lookups without one flop

---
 rtl/past_history_reader.sv | 105 ++++++++++
 tb/tb_past_history_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/past_history_reader.sv
`default_nettype none
// ============================================================================
//  Module      : past_history_reader
//  Description : Ring-buffer history of smp_data with a valid/ready lookup
//                port returning the value sampled N sampling edges ago
//                (hardware counterpart of $past(expr, N, gate)).
//                Optional feature macro: PAST_HIST_GATING_EN adds the smp_en
//                sample gate; without it every posedge is a sampling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module past_history_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] smp_data,
`ifdef PAST_HIST_GATING_EN
    input  logic             smp_en,
`endif
    input  logic             q_valid,
    input  logic [AW:0]      q_ticks,
    output logic             q_ready,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [WIDTH-1:0] r_data,
    output logic             r_hit,
    output logic             r_err
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW:0]      fill;

    logic             sample_fire;
    logic             q_accept;
    logic [AW-1:0]    rd_idx;
    logic             lk_err;
    logic             lk_hit;
    logic [WIDTH-1:0] lk_data;

`ifdef PAST_HIST_GATING_EN
    assign sample_fire = smp_en;
`else
    assign sample_fire = 1'b1;
`endif

    // Single-entry output register: accept whenever it is empty or draining.
    assign q_ready  = !r_valid || r_ready;
    assign q_accept = q_valid && q_ready;

    // Write pointer and saturating fill count advance on every sampling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= '0;
            fill <= '0;
        end else if (sample_fire) begin
            wp <= wp + 1'b1;
            if (fill != c_depth) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // History storage; never cleared, since fill masks stale entries.
    always_ff @(posedge clk) begin
        if (sample_fire) begin
            mem[wp] <= smp_data;
        end
    end

    // Lookup from pre-edge wp/fill so a same-edge write is not observed.
    // N == DEPTH wraps the index back onto wp, i.e. the oldest retained entry.
    always_comb begin
        rd_idx  = wp - q_ticks[AW-1:0];
        lk_err  = (q_ticks == '0) || (q_ticks > c_depth);
        lk_hit  = !lk_err && (q_ticks <= fill);
        lk_data = '0;
        if (lk_hit) begin
            lk_data = mem[rd_idx];
        end
    end

    // Response register: load on accept, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else if (q_accept) begin
            r_valid <= 1'b1;
            r_data  <= lk_data;
            r_hit   <= lk_hit;
            r_err   <= lk_err;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_past_history_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_past_history_reader
//  Description : Scoreboard bench for past_history_reader; a queue-based
//                history model predicts each response, a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_past_history_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic             hit;
        logic             err;
        logic [WIDTH-1:0] data;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] smp_data = '0;
    logic             smp_en = 1'b1;
    logic             q_valid = 1'b0;
    logic [AW:0]      q_ticks = '0;
    logic             r_ready = 1'b0;
    logic             q_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_hit;
    logic             r_err;

    int checks = 0;
    int passes = 0;

    resp_t            sb[$];
    logic [WIDTH-1:0] hist[$];   // hist[k] = sample k+1 sampling edges ago
    bit               m_valid = 1'b0;
    int               e = 0;     // edge index since reset release

    past_history_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .smp_data (smp_data),
`ifdef PAST_HIST_GATING_EN
        .smp_en   (smp_en),
`endif
        .q_valid  (q_valid),
        .q_ticks  (q_ticks),
        .q_ready  (q_ready),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .r_hit    (r_hit),
        .r_err    (r_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    endtask

    function automatic resp_t model_lookup(input int n);
        resp_t r;
        r = '0;
        if (n == 0 || n > DEPTH) r.err = 1'b1;
        else if (n <= hist.size()) begin
            r.hit  = 1'b1;
            r.data = hist[n-1];
        end
        return r;
    endfunction

    // Drive one edge's inputs (called at posedge+2), check handshake state,
    // update the model, then advance to the next posedge+2.
    task automatic cycle(input bit qv, input int n, input bit rr, input bit en,
                         input logic [WIDTH-1:0] d,
                         input bit use_exp, input bit eh, input bit ee, input int ed);
        resp_t r;
        bit    mq;
        bit    fire;
        q_valid  = qv;
        q_ticks  = n[AW:0];
        r_ready  = rr;
        smp_en   = en;
        smp_data = d;
        #1;
        check("r_valid", int'(r_valid), int'(m_valid));
        mq = !m_valid || rr;
        check("q_ready", int'(q_ready), int'(mq));
        if (qv && mq) begin
            r = model_lookup(n);
            if (use_exp) begin
                r.hit  = eh;
                r.err  = ee;
                r.data = ed[WIDTH-1:0];
            end
            sb.push_back(r);
            m_valid = 1'b1;
        end else if (rr) begin
            m_valid = 1'b0;
        end
`ifdef PAST_HIST_GATING_EN
        fire = en;
`else
        fire = 1'b1;
`endif
        if (fire) begin
            hist.push_front(d);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        e++;
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        rst     = 1'b1;
        q_valid = 1'b0;
        r_ready = 1'b0;
        #1;
        check("rst_r_valid", int'(r_valid), 0);
        check("rst_q_ready", int'(q_ready), 1);
        m_valid = 1'b0;
        sb.delete();
        hist.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        e   = 0;
    endtask

    // Monitor: compare each newly presented response and its hold stability.
    initial begin
        bit    fresh;
        resp_t exp;
        resp_t held;
        fresh = 1'b1;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fresh = 1'b1;
            end else begin
                if (r_valid) begin
                    if (fresh) begin
                        check("resp_expected", (sb.size() > 0) ? 1 : 0, 1);
                        if (sb.size() > 0) begin
                            exp = sb.pop_front();
                            check("r_data", int'(r_data), int'(exp.data));
                            check("r_hit",  int'(r_hit),  int'(exp.hit));
                            check("r_err",  int'(r_err),  int'(exp.err));
                        end
                        held = {r_hit, r_err, r_data};
                    end else begin
                        check("hold_stable", int'({r_hit, r_err, r_data}), int'(held));
                    end
                end
                fresh = !r_valid || r_ready;
            end
        end
    end

    initial begin
        int  n;
        bit  qv, rr, en;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_r_valid", int'(r_valid), 0);
        check("reset_r_data",  int'(r_data),  0);
        check("reset_r_hit",   int'(r_hit),   0);
        check("reset_r_err",   int'(r_err),   0);
        rst = 1'b0;
        e   = 0;

        // Directed lookups with smp_data = edge index.
        while (e < 43) begin
            case (e)
                2:  cycle(1, 3,  1, 1, e[WIDTH-1:0], 1, 0, 0, 0);
                5:  cycle(1, 0,  1, 1, e[WIDTH-1:0], 1, 0, 1, 0);
                6:  cycle(1, 17, 1, 1, e[WIDTH-1:0], 1, 0, 1, 0);
                10: cycle(1, 1,  1, 1, e[WIDTH-1:0], 1, 1, 0, 9);
                40: cycle(1, 16, 1, 1, e[WIDTH-1:0], 1, 1, 0, 24);
                41: cycle(1, 1,  1, 1, e[WIDTH-1:0], 1, 1, 0, 40);
                42: cycle(1, 16, 1, 1, e[WIDTH-1:0], 1, 1, 0, 26);
                default: cycle(0, 1, 1, 1, e[WIDTH-1:0], 0, 0, 0, 0);
            endcase
        end
        // Back-pressure: hold five cycles with a pending query, then refresh.
        cycle(1, 2, 1, 1, e[WIDTH-1:0], 1, 1, 0, 41);
        repeat (5) cycle(1, 3, 0, 1, e[WIDTH-1:0], 0, 0, 0, 0);
        cycle(1, 1, 1, 1, e[WIDTH-1:0], 1, 1, 0, 48);
        cycle(0, 1, 1, 1, e[WIDTH-1:0], 0, 0, 0, 0);

        // Reset while a response is held; history must restart empty.
        cycle(1, 1, 0, 1, e[WIDTH-1:0], 0, 0, 0, 0);
        cycle(0, 1, 0, 1, e[WIDTH-1:0], 0, 0, 0, 0);
        do_reset();
        cycle(1, 1, 1, 1, e[WIDTH-1:0], 1, 0, 0, 0);
        cycle(0, 1, 1, 1, e[WIDTH-1:0], 0, 0, 0, 0);

`ifdef PAST_HIST_GATING_EN
        // Gated sampling on even edges only.
        do_reset();
        while (e < 11) cycle(0, 1, 1, (e % 2) == 0, e[WIDTH-1:0], 0, 0, 0, 0);
        cycle(1, 1, 1, 0, e[WIDTH-1:0], 1, 1, 0, 10);
        cycle(0, 1, 1, 0, e[WIDTH-1:0], 0, 0, 0, 0);
`endif

        // Randomized traffic checked against the history model.
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) do_reset();
            n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                               : int'($urandom_range(1, DEPTH));
            qv = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 3) != 0);
`ifdef PAST_HIST_GATING_EN
            en = ($urandom_range(0, 3) != 0);
`else
            en = 1'b1;
`endif
            cycle(qv, n, rr, en, WIDTH'($urandom_range(0, 255)), 0, 0, 0, 0);
        end

        // Drain and confirm every predicted response was observed.
        repeat (4) cycle(0, 1, 1, 1, '0, 0, 0, 0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
